mic1_sequencer: RTL and testbench

Parametrised microsequencer for the MIC-1 control store. Computes the next microprogram counter (MPC) each cycle from the MIR next-address/JAM fields, the registered ALU flags and MBR. Adds a microcode call/return stack and a stall input for memory wait states. Sits between the control-store MIR register and the control-store address input.

---
 rtl/mic1_sequencer.sv | 125 ++++++++++++
 tb/tb_mic1_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mic1_sequencer.sv
// MIC-1 microsequencer: next-MPC from MIR NEXT_ADDRESS/JAM fields, latched ALU flags, MBR and a call/return stack.
// Latency: one cycle from MIR fields to mpc; all outputs come straight from flops.
// Backpressure: stall=1 freezes every piece of state; rst overrides stall.
module mic1_sequencer #(
    parameter int ADDR_W      = 9,
    parameter int MBR_W       = 8,
    parameter int STACK_DEPTH = 4,
    parameter int SP_W        = 3,
    parameter int RESET_ADDR  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              n_flag,
    input  logic              z_flag,
    input  logic [MBR_W-1:0]  mbr,
    input  logic [ADDR_W-1:0] next_addr,
    input  logic              jmpc,
    input  logic              jamn,
    input  logic              jamz,
    input  logic              call,
    input  logic              ret,
    output logic [ADDR_W-1:0] mpc,
    output logic [SP_W-1:0]   sp,
    output logic              stack_overflow,
    output logic              stack_underflow
);

    logic [ADDR_W-1:0] mpc_q, mpc_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              n_s_q, n_s_d;
    logic              z_s_q, z_s_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
    logic [ADDR_W-1:0] stack_d [STACK_DEPTH];

    logic              hi;
    logic [ADDR_W-2:0] lo;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] top_val;
    logic [SP_W-1:0]   sp_dec;

    // JAM uses the flags latched from the previous microinstruction.
    always_comb begin
        hi = next_addr[ADDR_W-1] | (jamz & z_s_q) | (jamn & n_s_q);
        lo = next_addr[ADDR_W-2:0];
        if (jmpc) begin
            lo = lo | (ADDR_W-1)'(mbr);
        end
        target = {hi, lo};
    end

    always_comb begin
        sp_dec  = sp_q - SP_W'(1);
        top_val = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (SP_W'(i) == sp_dec) begin
                top_val = stack_q[i];
            end
        end
    end

    always_comb begin
        mpc_d   = mpc_q;
        sp_d    = sp_q;
        n_s_d   = n_s_q;
        z_s_d   = z_s_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        stack_d = stack_q;
        if (!stall) begin
            n_s_d = n_flag;
            z_s_d = z_flag;
            if (ret) begin
                if (sp_q != '0) begin
                    mpc_d = top_val;
                    sp_d  = sp_dec;
                end else begin
                    mpc_d = target;
                    udf_d = 1'b1;
                end
            end else if (call) begin
                mpc_d = target;
                if (sp_q < SP_W'(STACK_DEPTH)) begin
                    for (int i = 0; i < STACK_DEPTH; i++) begin
                        if (SP_W'(i) == sp_q) begin
                            stack_d[i] = mpc_q + ADDR_W'(1);
                        end
                    end
                    sp_d = sp_q + SP_W'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end else begin
                mpc_d = target;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mpc_q <= ADDR_W'(RESET_ADDR);
            sp_q  <= '0;
            n_s_q <= 1'b0;
            z_s_q <= 1'b0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            mpc_q   <= mpc_d;
            sp_q    <= sp_d;
            n_s_q   <= n_s_d;
            z_s_q   <= z_s_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            stack_q <= stack_d;
        end
    end

    assign mpc             = mpc_q;
    assign sp              = sp_q;
    assign stack_overflow  = ovf_q;
    assign stack_underflow = udf_q;

endmodule

// File: tb/tb_mic1_sequencer.sv
// Bench for mic1_sequencer: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_mic1_sequencer;

    logic       clk = 1'b0;
    logic       rst, stall, n_flag, z_flag, jmpc, jamn, jamz, call, ret;
    logic [7:0] mbr;
    logic [8:0] next_addr;
    logic [8:0] mpc;
    logic [2:0] sp;
    logic       stack_overflow, stack_underflow;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int m_mpc;
    int m_n, m_z, m_ovf, m_udf;
    int m_stack[$];

    always #5 clk = ~clk;

    mic1_sequencer dut (
        .clk(clk), .rst(rst), .stall(stall), .n_flag(n_flag), .z_flag(z_flag),
        .mbr(mbr), .next_addr(next_addr), .jmpc(jmpc), .jamn(jamn), .jamz(jamz),
        .call(call), .ret(ret), .mpc(mpc), .sp(sp),
        .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
    );

    // Drive one microinstruction, advance the model, clock once, sample #1 after the edge.
    task automatic step(input int r, input int st, input int n, input int z, input int mb,
                        input int na, input int jc, input int jn, input int jz,
                        input int c, input int rt);
        int hi, lo, tgt;
        rst = r[0]; stall = st[0]; n_flag = n[0]; z_flag = z[0];
        mbr = mb[7:0]; next_addr = na[8:0];
        jmpc = jc[0]; jamn = jn[0]; jamz = jz[0]; call = c[0]; ret = rt[0];
        hi  = ((na >= 256) || (jz != 0 && m_z != 0) || (jn != 0 && m_n != 0)) ? 1 : 0;
        lo  = (jc != 0) ? ((na % 256) | mb) : (na % 256);
        tgt = hi * 256 + lo;
        if (r != 0) begin
            m_mpc = 0; m_n = 0; m_z = 0; m_ovf = 0; m_udf = 0;
            m_stack.delete();
        end else if (st == 0) begin
            if (rt != 0) begin
                if (m_stack.size() > 0) m_mpc = m_stack.pop_back();
                else begin m_mpc = tgt; m_udf = 1; end
            end else if (c != 0) begin
                if (m_stack.size() < 4) m_stack.push_back((m_mpc + 1) % 512);
                else m_ovf = 1;
                m_mpc = tgt;
            end else begin
                m_mpc = tgt;
            end
            m_n = n; m_z = z;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic plain(input int na);
        step(0, 0, 0, 0, 0, na, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset;
        step(1, 0, 1, 1, 8'hFF, 9'h1FF, 1, 1, 1, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (mpc !== 9'h000 || sp !== 3'd0 || stack_overflow !== 1'b0 || stack_underflow !== 1'b0) begin
            failures++;
            $display("FAIL reset: mpc=%h sp=%0d ovf=%b udf=%b, want 000 0 0 0", mpc, sp, stack_overflow, stack_underflow);
        end
        plain(9'h012);
        checks++;
        if (mpc !== 9'h012) begin
            failures++; $display("FAIL plain: mpc=%h want 012", mpc);
        end
    endtask

    task automatic test_jam;
        step(0, 0, 0, 1, 0, 9'h005, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 9'h092, 0, 0, 1, 0, 0);
        checks++;
        if (mpc !== 9'h192) begin failures++; $display("FAIL jamz_taken: mpc=%h want 192", mpc); end
        step(0, 0, 0, 0, 0, 9'h092, 0, 0, 1, 0, 0);
        checks++;
        if (mpc !== 9'h092) begin failures++; $display("FAIL jamz_not_taken: mpc=%h want 092", mpc); end
        step(0, 0, 1, 0, 0, 9'h007, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 9'h000, 0, 1, 0, 0, 0);
        checks++;
        if (mpc !== 9'h100) begin failures++; $display("FAIL jamn_taken: mpc=%h want 100", mpc); end
    endtask

    task automatic test_jmpc;
        step(0, 0, 0, 0, 8'h60, 9'h100, 1, 0, 0, 0, 0);
        checks++;
        if (mpc !== 9'h160) begin failures++; $display("FAIL jmpc_160: mpc=%h want 160", mpc); end
        step(0, 0, 0, 0, 8'h0F, 9'h0F0, 1, 0, 0, 0, 0);
        checks++;
        if (mpc !== 9'h0FF) begin failures++; $display("FAIL jmpc_bitwise: mpc=%h want 0ff", mpc); end
    endtask

    task automatic test_call_ret;
        plain(9'h020);
        step(0, 0, 0, 0, 0, 9'h080, 0, 0, 0, 1, 0);
        checks++;
        if (mpc !== 9'h080 || sp !== 3'd1) begin
            failures++; $display("FAIL call: mpc=%h sp=%0d want 080 1", mpc, sp);
        end
        step(0, 0, 0, 0, 0, 9'h055, 0, 0, 0, 0, 1);
        checks++;
        if (mpc !== 9'h021 || sp !== 3'd0) begin
            failures++; $display("FAIL ret: mpc=%h sp=%0d want 021 0", mpc, sp);
        end
        plain(9'h1FF);
        step(0, 0, 0, 0, 0, 9'h005, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 9'h006, 0, 0, 0, 0, 1);
        checks++;
        if (mpc !== 9'h000 || sp !== 3'd0) begin
            failures++; $display("FAIL call_wrap: mpc=%h sp=%0d want 000 0", mpc, sp);
        end
    endtask

    task automatic test_overflow_underflow;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        plain(9'h010);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 9'h040 + i, 0, 0, 0, 1, 0);
        checks++;
        if (sp !== 3'd4 || stack_overflow !== 1'b1 || mpc !== 9'h044) begin
            failures++; $display("FAIL overflow: sp=%0d ovf=%b mpc=%h want 4 1 044", sp, stack_overflow, mpc);
        end
        step(0, 0, 0, 0, 0, 9'h000, 0, 0, 0, 0, 1);
        checks++;
        if (mpc !== 9'h043 || sp !== 3'd3) begin
            failures++; $display("FAIL top_intact: mpc=%h sp=%0d want 043 3", mpc, sp);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 9'h000, 0, 0, 0, 0, 1);
        checks++;
        if (mpc !== 9'h011 || sp !== 3'd0 || stack_underflow !== 1'b0) begin
            failures++; $display("FAIL drain: mpc=%h sp=%0d udf=%b want 011 0 0", mpc, sp, stack_underflow);
        end
        step(0, 0, 0, 0, 0, 9'h033, 0, 0, 0, 0, 1);
        checks++;
        if (mpc !== 9'h033 || sp !== 3'd0 || stack_underflow !== 1'b1 || stack_overflow !== 1'b1) begin
            failures++; $display("FAIL underflow: mpc=%h sp=%0d udf=%b ovf=%b want 033 0 1 1", mpc, sp, stack_underflow, stack_overflow);
        end
        step(0, 0, 0, 0, 0, 9'h050, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 9'h070, 0, 0, 0, 1, 1);
        checks++;
        if (mpc !== 9'h034 || sp !== 3'd0) begin
            failures++; $display("FAIL call_and_ret: mpc=%h sp=%0d want 034 0", mpc, sp);
        end
    endtask

    task automatic test_stall_reset;
        logic [8:0] mpc_before;
        logic [2:0] sp_before;
        step(0, 0, 0, 0, 0, 9'h060, 0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0, 9'h0A0, 0, 0, 0, 0, 0);
        mpc_before = mpc; sp_before = sp;
        for (int i = 0; i < 3; i++)
            step(0, 1, i % 2, 1, 8'hAA, (i % 2) ? 9'h1C3 : 9'h03C, 1, 1, 1, (i + 1) % 2, i % 2);
        checks++;
        if (mpc !== mpc_before || sp !== sp_before || mpc !== 9'h0A0 || sp !== 3'd1) begin
            failures++; $display("FAIL stall_hold: mpc=%h sp=%0d want 0a0 1", mpc, sp);
        end
        step(0, 0, 0, 0, 0, 9'h000, 0, 1, 0, 0, 0);
        checks++;
        if (mpc !== 9'h100) begin failures++; $display("FAIL stall_flag_hold: mpc=%h want 100", mpc); end
        step(1, 1, 0, 0, 0, 9'h0F0, 0, 0, 0, 1, 0);
        checks++;
        if (mpc !== 9'h000 || sp !== 3'd0 || stack_overflow !== 1'b0 || stack_underflow !== 1'b0) begin
            failures++; $display("FAIL stall_reset: mpc=%h sp=%0d ovf=%b udf=%b want 000 0 0 0", mpc, sp, stack_overflow, stack_underflow);
        end
    endtask

    task automatic test_random;
        int bad = 0;
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0) ? 1 : 0, ($urandom_range(0, 4) == 0) ? 1 : 0,
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 255),
                 $urandom_range(0, 511), ($urandom_range(0, 3) == 0) ? 1 : 0,
                 $urandom_range(0, 1), $urandom_range(0, 1),
                 ($urandom_range(0, 3) == 0) ? 1 : 0, ($urandom_range(0, 3) == 0) ? 1 : 0);
            checks++;
            if (int'(mpc) != m_mpc || int'(sp) != m_stack.size() ||
                int'(stack_overflow) != m_ovf || int'(stack_underflow) != m_udf) begin
                failures++;
                if (bad < 10)
                    $display("FAIL random[%0d]: mpc=%h sp=%0d ovf=%b udf=%b want %h %0d %0d %0d",
                             i, mpc, sp, stack_overflow, stack_underflow, m_mpc, m_stack.size(), m_ovf, m_udf);
                bad++;
            end
        end
    endtask

    initial begin
        m_mpc = 0; m_n = 0; m_z = 0; m_ovf = 0; m_udf = 0;
        rst = 1'b1; stall = 1'b0; n_flag = 1'b0; z_flag = 1'b0; mbr = '0; next_addr = '0;
        jmpc = 1'b0; jamn = 1'b0; jamz = 1'b0; call = 1'b0; ret = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_jam();
        test_jmpc();
        test_call_ret();
        test_overflow_underflow();
        test_stall_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
